// File: rtl/context_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : context_scheduler
// Purpose : Preemptive round-robin scheduler for a 4-slot hardware context
//           mechanism (saved-PC table, running process, time slice).
// Revision: 1.0 - initial release
// ============================================================================
module context_scheduler #(
  parameter int QUANTUM     = 64,
  parameter int PC_W        = 13,
  parameter int SLOT_STRIDE = 512
) (
  input  logic                       Slow_Clock,
  input  logic                       Reset,
  input  logic                       Preempt_En,
  input  logic                       Stall,
  input  logic [PC_W-1:0]            Next_PC,
  input  logic                       Sw_Req,
  input  logic [1:0]                 Sw_Target,
  input  logic                       Proc_Halt,
  input  logic [3:0]                 Proc_Wake,
  output logic                       Change_Context,
  output logic [PC_W-1:0]            Context_PC,
  output logic [1:0]                 Proc_ID,
  output logic [3:0]                 Active_Mask,
  output logic                       Idle,
  output logic [$clog2(QUANTUM)-1:0] Slice_Count
);

  localparam int              c_CNT_W   = $clog2(QUANTUM);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(QUANTUM - 1);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t               r_state, w_state_nx;
  logic [PC_W-1:0]      r_table [4];
  logic [1:0]           r_proc_id, w_pid_nx;
  logic [3:0]           r_mask, w_mask_nx;
  logic                 r_idle, w_idle_nx;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt_nx;

  logic                 w_run_ok;
  logic                 w_halt_acc;
  logic [3:0]           w_halt_bit;
  logic [3:0]           w_act_n;
  logic [1:0]           w_pick;
  logic                 w_pick_found;
  logic                 w_wr_en;
  logic                 w_cc;
  logic [PC_W-1:0]      w_cpc;

  // Switch sources only count while running and not frozen by IO wait.
  assign w_run_ok   = (r_state == ST_RUN) && !Stall;
  assign w_halt_acc = w_run_ok && Proc_Halt;
  assign w_halt_bit = w_halt_acc ? (4'b0001 << r_proc_id) : 4'b0000;
  assign w_act_n    = (r_mask & ~w_halt_bit) | Proc_Wake;

  // Round-robin: nearest successor wins; the running process is the fallback.
  always_comb begin
    logic [1:0] idx;
    w_pick       = r_proc_id;
    w_pick_found = w_act_n[r_proc_id];
    idx          = r_proc_id;
    for (int k = 3; k >= 1; k--) begin
      idx = r_proc_id + 2'(k);
      if (w_act_n[idx]) begin
        w_pick       = idx;
        w_pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_pid_nx   = r_proc_id;
    w_mask_nx  = w_act_n;
    w_idle_nx  = r_idle;
    w_cnt_nx   = r_cnt;
    w_wr_en    = 1'b0;
    w_cc       = 1'b0;
    w_cpc      = r_table[r_proc_id];
    case (r_state)
      ST_RUN: begin
        if (w_halt_acc) begin
          w_wr_en  = 1'b1;
          w_cnt_nx = '0;
          if (w_pick_found) begin
            w_cc     = 1'b1;
            // A halting process re-woken in the same cycle resumes at Next_PC.
            w_cpc    = (w_pick == r_proc_id) ? Next_PC : r_table[w_pick];
            w_pid_nx = w_pick;
          end else begin
            w_state_nx = ST_IDLE;
            w_idle_nx  = 1'b1;
          end
        end else if (w_run_ok && Sw_Req) begin
          w_wr_en   = 1'b1;
          w_cnt_nx  = '0;
          w_cc      = 1'b1;
          w_cpc     = (Sw_Target == r_proc_id) ? Next_PC : r_table[Sw_Target];
          w_pid_nx  = Sw_Target;
          w_mask_nx = w_act_n | (4'b0001 << Sw_Target);
        end else if (w_run_ok && Preempt_En && (r_cnt == c_CNT_MAX)
                     && w_pick_found && (w_pick != r_proc_id)) begin
          w_wr_en  = 1'b1;
          w_cnt_nx = '0;
          w_cc     = 1'b1;
          w_cpc    = r_table[w_pick];
          w_pid_nx = w_pick;
        end else if (!Stall) begin
          w_cnt_nx = (r_cnt == c_CNT_MAX) ? '0 : r_cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        w_cnt_nx = '0;
        if (|w_act_n) begin
          w_cc       = 1'b1;
          w_cpc      = r_table[w_pick];
          w_pid_nx   = w_pick;
          w_idle_nx  = 1'b0;
          w_state_nx = ST_RUN;
        end
      end
      default: w_state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge Slow_Clock or posedge Reset) begin
    if (Reset) begin
      r_state   <= ST_RUN;
      r_proc_id <= 2'd0;
      r_mask    <= 4'b0001;
      r_idle    <= 1'b0;
      r_cnt     <= '0;
      for (int i = 0; i < 4; i++) begin
        r_table[i] <= PC_W'(i * SLOT_STRIDE);
      end
    end else begin
      r_state   <= w_state_nx;
      r_proc_id <= w_pid_nx;
      r_mask    <= w_mask_nx;
      r_idle    <= w_idle_nx;
      r_cnt     <= w_cnt_nx;
      if (w_wr_en) begin
        r_table[r_proc_id] <= Next_PC;
      end
    end
  end

  assign Change_Context = w_cc;
  assign Context_PC     = w_cpc;
  assign Proc_ID        = r_proc_id;
  assign Active_Mask    = r_mask;
  assign Idle           = r_idle;
  assign Slice_Count    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_context_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_context_scheduler
// Purpose : Directed vector bench for context_scheduler (QUANTUM=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_context_scheduler;

  localparam int QUANTUM     = 4;
  localparam int PC_W        = 13;
  localparam int SLOT_STRIDE = 512;
  localparam int NV          = 30;

  logic            clk = 1'b0;
  logic            rst;
  logic            pe, st, sw, ht;
  logic [PC_W-1:0] npc;
  logic [1:0]      tg;
  logic [3:0]      wk;
  logic            cc;
  logic [PC_W-1:0] cpc;
  logic [1:0]      pid;
  logic [3:0]      mask;
  logic            idle;
  logic [1:0]      cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  context_scheduler #(
    .QUANTUM    (QUANTUM),
    .PC_W       (PC_W),
    .SLOT_STRIDE(SLOT_STRIDE)
  ) dut (
    .Slow_Clock    (clk),
    .Reset         (rst),
    .Preempt_En    (pe),
    .Stall         (st),
    .Next_PC       (npc),
    .Sw_Req        (sw),
    .Sw_Target     (tg),
    .Proc_Halt     (ht),
    .Proc_Wake     (wk),
    .Change_Context(cc),
    .Context_PC    (cpc),
    .Proc_ID       (pid),
    .Active_Mask   (mask),
    .Idle          (idle),
    .Slice_Count   (cnt)
  );

  typedef struct {
    logic            pe, st;
    logic [PC_W-1:0] npc;
    logic            sw;
    logic [1:0]      tg;
    logic            ht;
    logic [3:0]      wk;
    logic            cc;
    logic [PC_W-1:0] cpc;
    logic [1:0]      pid;
    logic [3:0]      mask;
    logic            idle;
    logic [1:0]      cnt;
  } vec_t;

  vec_t vt [NV];

  function automatic vec_t mk(
    input logic i_pe, input logic i_st, input logic [PC_W-1:0] i_npc,
    input logic i_sw, input logic [1:0] i_tg, input logic i_ht, input logic [3:0] i_wk,
    input logic e_cc, input logic [PC_W-1:0] e_cpc, input logic [1:0] e_pid,
    input logic [3:0] e_mask, input logic e_idle, input logic [1:0] e_cnt);
    vec_t v;
    v.pe = i_pe; v.st = i_st; v.npc = i_npc; v.sw = i_sw; v.tg = i_tg;
    v.ht = i_ht; v.wk = i_wk;
    v.cc = e_cc; v.cpc = e_cpc; v.pid = e_pid; v.mask = e_mask;
    v.idle = e_idle; v.cnt = e_cnt;
    return v;
  endfunction

  task automatic drive(input logic i_pe, input logic i_st, input logic [PC_W-1:0] i_npc,
                       input logic i_sw, input logic [1:0] i_tg, input logic i_ht,
                       input logic [3:0] i_wk);
    pe = i_pe; st = i_st; npc = i_npc; sw = i_sw; tg = i_tg; ht = i_ht; wk = i_wk;
  endtask

  // Outputs packed as {cc, cpc, pid, mask, idle, cnt}.
  task automatic chk(input string nm, input logic e_cc, input logic [PC_W-1:0] e_cpc,
                     input logic [1:0] e_pid, input logic [3:0] e_mask,
                     input logic e_idle, input logic [1:0] e_cnt);
    logic [22:0] act, exp_v;
    act   = {cc, cpc, pid, mask, idle, cnt};
    exp_v = {e_cc, e_cpc, e_pid, e_mask, e_idle, e_cnt};
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got cc=%b pc=%h id=%0d mask=%b idle=%b cnt=%0d, want cc=%b pc=%h id=%0d mask=%b idle=%b cnt=%0d",
               nm, cc, cpc, pid, mask, idle, cnt, e_cc, e_cpc, e_pid, e_mask, e_idle, e_cnt);
    end
  endtask

  initial begin
    // Columns: pe st npc sw tg ht wk | cc cpc pid mask idle cnt
    vt[0]  = mk(1,0,13'h001,0,0,0,4'b0000, 0,13'h000,0,4'b0001,0,0);
    vt[1]  = mk(1,0,13'h000,0,0,0,4'b0000, 0,13'h000,0,4'b0001,0,1);
    vt[2]  = mk(1,0,13'h000,0,0,0,4'b0010, 0,13'h000,0,4'b0001,0,2);
    vt[3]  = mk(1,0,13'h033,0,0,0,4'b0000, 1,13'h200,0,4'b0011,0,3);
    vt[4]  = mk(1,0,13'h000,0,0,0,4'b0000, 0,13'h200,1,4'b0011,0,0);
    vt[5]  = mk(1,0,13'h200,1,0,0,4'b0000, 1,13'h033,1,4'b0011,0,1);
    vt[6]  = mk(1,0,13'h0A5,1,3,0,4'b0000, 1,13'h600,0,4'b0011,0,0);
    vt[7]  = mk(1,0,13'h123,1,3,0,4'b0000, 1,13'h123,3,4'b1011,0,0);
    vt[8]  = mk(1,0,13'h444,1,0,0,4'b0000, 1,13'h0A5,3,4'b1011,0,0);
    vt[9]  = mk(1,0,13'h210,0,0,1,4'b0000, 1,13'h200,0,4'b1011,0,0);
    vt[10] = mk(1,0,13'h0BB,0,0,1,4'b0000, 1,13'h444,1,4'b1010,0,0);
    vt[11] = mk(1,0,13'h0CC,1,1,1,4'b0000, 0,13'h444,3,4'b1000,0,0);
    vt[12] = mk(1,0,13'h000,1,2,1,4'b0000, 0,13'h0CC,3,4'b0000,1,0);
    vt[13] = mk(1,0,13'h000,0,0,0,4'b0000, 0,13'h0CC,3,4'b0000,1,0);
    vt[14] = mk(1,0,13'h000,0,0,0,4'b0100, 1,13'h400,3,4'b0000,1,0);
    vt[15] = mk(1,0,13'h000,0,0,0,4'b0000, 0,13'h400,2,4'b0100,0,0);
    vt[16] = mk(1,0,13'h000,0,0,0,4'b0000, 0,13'h400,2,4'b0100,0,1);
    vt[17] = mk(1,0,13'h000,0,0,0,4'b0000, 0,13'h400,2,4'b0100,0,2);
    vt[18] = mk(1,0,13'h000,0,0,0,4'b0000, 0,13'h400,2,4'b0100,0,3);
    vt[19] = mk(1,0,13'h000,0,0,0,4'b0001, 0,13'h400,2,4'b0100,0,0);
    vt[20] = mk(1,0,13'h000,0,0,0,4'b0000, 0,13'h400,2,4'b0101,0,1);
    vt[21] = mk(1,0,13'h000,0,0,0,4'b0000, 0,13'h400,2,4'b0101,0,2);
    vt[22] = mk(1,1,13'h000,1,0,1,4'b0000, 0,13'h400,2,4'b0101,0,3);
    vt[23] = mk(1,1,13'h000,1,0,1,4'b0000, 0,13'h400,2,4'b0101,0,3);
    vt[24] = mk(0,0,13'h000,0,0,0,4'b0000, 0,13'h400,2,4'b0101,0,3);
    vt[25] = mk(1,0,13'h000,0,0,0,4'b0000, 0,13'h400,2,4'b0101,0,0);
    vt[26] = mk(1,0,13'h077,0,0,1,4'b0100, 1,13'h210,2,4'b0101,0,1);
    vt[27] = mk(1,0,13'h000,0,0,0,4'b0000, 0,13'h210,0,4'b0101,0,0);
    vt[28] = mk(1,0,13'h011,1,2,0,4'b0000, 1,13'h077,0,4'b0101,0,1);
    vt[29] = mk(1,0,13'h000,0,0,0,4'b0000, 0,13'h077,2,4'b0101,0,0);

    rst = 1'b1;
    drive(1, 0, '0, 0, 0, 0, 4'b0000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].pe, vt[i].st, vt[i].npc, vt[i].sw, vt[i].tg, vt[i].ht, vt[i].wk);
      @(negedge clk);
      chk($sformatf("vec%0d", i), vt[i].cc, vt[i].cpc, vt[i].pid, vt[i].mask,
          vt[i].idle, vt[i].cnt);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-slice, checked before any clock edge.
    drive(1, 0, '0, 0, 0, 0, 4'b0000);
    #2 rst = 1'b1;
    #1 chk("async_reset_run", 0, 13'h000, 0, 4'b0001, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Table contents must be back to their reset values.
    drive(1, 0, 13'h005, 1, 1, 0, 4'b0000);
    @(negedge clk);
    chk("table_reset_sw1", 1, 13'h200, 0, 4'b0001, 0, 0);
    @(posedge clk);
    #1 drive(1, 0, 13'h007, 0, 0, 1, 4'b0000);
    @(negedge clk);
    chk("halt_to_p0", 1, 13'h005, 1, 4'b0011, 0, 0);
    @(posedge clk);
    #1 drive(1, 0, 13'h009, 0, 0, 1, 4'b0000);
    @(negedge clk);
    chk("halt_last", 0, 13'h005, 0, 4'b0001, 0, 0);
    @(posedge clk);
    #1 drive(1, 0, 13'h000, 0, 0, 0, 4'b0000);
    @(negedge clk);
    chk("idle_entered", 0, 13'h009, 0, 4'b0000, 1, 0);
    #1 rst = 1'b1;
    #1 chk("async_reset_idle", 0, 13'h000, 0, 4'b0001, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
